wb_port_arbiter: RTL and testbench

Shares the single 64-bit register-file write port between two writeback requesters: A (ALU/execute result) and B (memory load data). It arbitrates with round-robin priority and drives the select of the 2:1 64-bit writeback mux. The muxed result is registered onto the register-file write port. It sits at the end of the pipeline, between the EX/MEM result buses and the register file.

---
 rtl/wb_port_arbiter_pkg.sv | 12 +
 rtl/MUX2_1_64.sv | 13 +
 rtl/wb_port_arbiter.sv | 112 +++++++++++
 tb/tb_wb_port_arbiter.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/wb_port_arbiter_pkg.sv
// Shared constants and types for the writeback port arbiter.
// Grant encoding doubles as the writeback mux select encoding.
package wb_port_arbiter_pkg;

  localparam int unsigned ZERO_REG = 31;

  typedef enum logic {
    GRANT_A = 1'b0,
    GRANT_B = 1'b1
  } grant_e;

endpackage

// File: rtl/MUX2_1_64.sv
// Existing 2:1 writeback data mux; S=0 selects A, S=1 selects B.
module MUX2_1_64 #(
  parameter int unsigned W = 64
) (
  input  logic [W-1:0] A,
  input  logic [W-1:0] B,
  input  logic         S,
  output logic [W-1:0] Y
);

  assign Y = S ? B : A;

endmodule

// File: rtl/wb_port_arbiter.sv
// Round-robin arbiter sharing the register-file write port between the
// execute result (A) and load data (B); the selected result is registered.
module wb_port_arbiter #(
  parameter int unsigned DATA_W   = 64,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned ZERO_REG = wb_port_arbiter_pkg::ZERO_REG,
  parameter int unsigned CNT_W    = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              a_valid,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_data,
  output logic              a_ready,
  input  logic              b_valid,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_data,
  output logic              b_ready,
  output logic              mux_sel,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              stall_a,
  output logic              stall_b,
  output logic [CNT_W-1:0]  conflict_cnt
);

  import wb_port_arbiter_pkg::*;

  localparam logic [ADDR_W-1:0] ZeroAddr = ADDR_W'(ZERO_REG);
  localparam logic [CNT_W-1:0]  CntMax   = {CNT_W{1'b1}};

  grant_e              last_grant_q, last_grant_d;
  grant_e              grant;
  logic                grant_valid;
  logic                conflict;
  logic [ADDR_W-1:0]   waddr;
  logic [DATA_W-1:0]   wdata;

  logic                rf_we_q;
  logic [ADDR_W-1:0]   rf_waddr_q;
  logic [DATA_W-1:0]   rf_wdata_q;
  logic [CNT_W-1:0]    conflict_cnt_q;

  assign conflict = a_valid & b_valid;

  // Grant is suppressed during reset so pending requests are dropped.
  always_comb begin
    grant        = GRANT_A;
    grant_valid  = 1'b0;
    last_grant_d = last_grant_q;
    if (!reset) begin
      if (conflict) begin
        grant_valid = 1'b1;
        grant       = (last_grant_q == GRANT_A) ? GRANT_B : GRANT_A;
      end else if (a_valid) begin
        grant_valid = 1'b1;
        grant       = GRANT_A;
      end else if (b_valid) begin
        grant_valid = 1'b1;
        grant       = GRANT_B;
      end
    end
    if (grant_valid) begin
      last_grant_d = grant;
    end
  end

  assign a_ready = grant_valid & (grant == GRANT_A);
  assign b_ready = grant_valid & (grant == GRANT_B);
  assign mux_sel = grant_valid & (grant == GRANT_B);
  assign stall_a = a_valid & ~a_ready;
  assign stall_b = b_valid & ~b_ready;

  assign waddr = mux_sel ? b_addr : a_addr;

  MUX2_1_64 #(
    .W (DATA_W)
  ) u_wb_mux (
    .A (a_data),
    .B (b_data),
    .S (mux_sel),
    .Y (wdata)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant_q   <= GRANT_B;
      rf_we_q        <= 1'b0;
      rf_waddr_q     <= '0;
      rf_wdata_q     <= '0;
      conflict_cnt_q <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      // Writes to the zero register are acknowledged but never enabled.
      rf_we_q      <= grant_valid && (waddr != ZeroAddr);
      if (grant_valid) begin
        rf_waddr_q <= waddr;
        rf_wdata_q <= wdata;
      end
      if (conflict && (conflict_cnt_q != CntMax)) begin
        conflict_cnt_q <= conflict_cnt_q + 1'b1;
      end
    end
  end

  assign rf_we        = rf_we_q;
  assign rf_waddr     = rf_waddr_q;
  assign rf_wdata     = rf_wdata_q;
  assign conflict_cnt = conflict_cnt_q;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter; a second instance with a 2-bit
// conflict counter covers saturation.
module tb_wb_port_arbiter;

  logic        clk;
  logic        reset;
  logic        a_valid, b_valid;
  logic [4:0]  a_addr, b_addr;
  logic [63:0] a_data, b_data;

  logic        a_ready, b_ready, mux_sel, rf_we, stall_a, stall_b;
  logic [4:0]  rf_waddr;
  logic [63:0] rf_wdata;
  logic [15:0] conflict_cnt;

  logic        d2_a_ready, d2_b_ready, d2_mux_sel, d2_rf_we, d2_stall_a, d2_stall_b;
  logic [4:0]  d2_rf_waddr;
  logic [63:0] d2_rf_wdata;
  logic [1:0]  d2_conflict_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  wb_port_arbiter dut (
    .clk          (clk),
    .reset        (reset),
    .a_valid      (a_valid),
    .a_addr       (a_addr),
    .a_data       (a_data),
    .a_ready      (a_ready),
    .b_valid      (b_valid),
    .b_addr       (b_addr),
    .b_data       (b_data),
    .b_ready      (b_ready),
    .mux_sel      (mux_sel),
    .rf_we        (rf_we),
    .rf_waddr     (rf_waddr),
    .rf_wdata     (rf_wdata),
    .stall_a      (stall_a),
    .stall_b      (stall_b),
    .conflict_cnt (conflict_cnt)
  );

  wb_port_arbiter #(
    .CNT_W (2)
  ) dut2 (
    .clk          (clk),
    .reset        (reset),
    .a_valid      (a_valid),
    .a_addr       (a_addr),
    .a_data       (a_data),
    .a_ready      (d2_a_ready),
    .b_valid      (b_valid),
    .b_addr       (b_addr),
    .b_data       (b_data),
    .b_ready      (d2_b_ready),
    .mux_sel      (d2_mux_sel),
    .rf_we        (d2_rf_we),
    .rf_waddr     (d2_rf_waddr),
    .rf_wdata     (d2_rf_wdata),
    .stall_a      (d2_stall_a),
    .stall_b      (d2_stall_b),
    .conflict_cnt (d2_conflict_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset   = 1'b1;
    a_valid = 1'b0; a_addr = '0; a_data = '0;
    b_valid = 1'b0; b_addr = '0; b_data = '0;

    // Reset then idle
    #1;
    check_eq("rst_a_ready", a_ready, 0);
    check_eq("rst_b_ready", b_ready, 0);
    tick();
    tick();
    check_eq("rst_rf_we", rf_we, 0);
    check_eq("rst_rf_wdata", rf_wdata, 0);
    check_eq("rst_cnt", conflict_cnt, 0);
    reset = 1'b0;
    #1;
    check_eq("idle_a_ready", a_ready, 0);
    check_eq("idle_b_ready", b_ready, 0);
    check_eq("idle_mux_sel", mux_sel, 0);
    tick();
    check_eq("idle_rf_we", rf_we, 0);

    // Single requester A
    a_valid = 1'b1; a_addr = 5'd3; a_data = 64'd5;
    #1;
    check_eq("single_a_ready", a_ready, 1);
    check_eq("single_b_ready", b_ready, 0);
    check_eq("single_mux_sel", mux_sel, 0);
    check_eq("single_stall_a", stall_a, 0);
    tick();
    a_valid = 1'b0;
    check_eq("single_rf_we", rf_we, 1);
    check_eq("single_rf_waddr", rf_waddr, 3);
    check_eq("single_rf_wdata", rf_wdata, 5);
    tick();
    check_eq("single_idle_we", rf_we, 0);
    check_eq("single_hold_waddr", rf_waddr, 3);
    check_eq("single_hold_wdata", rf_wdata, 5);

    // Reset mid-conflict, then tie round-robin from reset
    reset   = 1'b1;
    a_valid = 1'b1; a_addr = 5'd1; a_data = 64'd10;
    b_valid = 1'b1; b_addr = 5'd2; b_data = 64'd6;
    #1;
    check_eq("midrst_a_ready", a_ready, 0);
    check_eq("midrst_b_ready", b_ready, 0);
    check_eq("midrst_mux_sel", mux_sel, 0);
    tick();
    check_eq("midrst_rf_we", rf_we, 0);
    check_eq("midrst_cnt", conflict_cnt, 0);
    check_eq("midrst_cnt2", d2_conflict_cnt, 0);
    reset = 1'b0;
    #1;
    check_eq("tie0_a_ready", a_ready, 1);
    check_eq("tie0_b_ready", b_ready, 0);
    check_eq("tie0_mux_sel", mux_sel, 0);
    check_eq("tie0_stall_b", stall_b, 1);
    check_eq("tie0_stall_a", stall_a, 0);
    tick();
    check_eq("tie0_rf_we", rf_we, 1);
    check_eq("tie0_rf_waddr", rf_waddr, 1);
    check_eq("tie0_rf_wdata", rf_wdata, 10);
    check_eq("tie0_cnt", conflict_cnt, 1);
    check_eq("tie1_b_ready", b_ready, 1);
    check_eq("tie1_a_ready", a_ready, 0);
    check_eq("tie1_mux_sel", mux_sel, 1);
    check_eq("tie1_stall_a", stall_a, 1);
    check_eq("tie1_stall_b", stall_b, 0);
    tick();
    check_eq("tie1_rf_waddr", rf_waddr, 2);
    check_eq("tie1_rf_wdata", rf_wdata, 6);
    check_eq("tie1_cnt", conflict_cnt, 2);
    check_eq("tie1_cnt2", d2_conflict_cnt, 2);
    check_eq("tie2_a_ready", a_ready, 1);
    check_eq("tie2_mux_sel", mux_sel, 0);
    tick();
    check_eq("tie2_rf_waddr", rf_waddr, 1);
    check_eq("tie2_rf_wdata", rf_wdata, 10);
    check_eq("sat3_cnt2", d2_conflict_cnt, 3);
    tick();
    tick();
    check_eq("sat5_cnt2", d2_conflict_cnt, 3);
    check_eq("sat5_cnt", conflict_cnt, 5);

    // Zero register write from B
    a_valid = 1'b0;
    b_valid = 1'b1; b_addr = 5'd31; b_data = 64'd4;
    #1;
    check_eq("zr_b_ready", b_ready, 1);
    check_eq("zr_mux_sel", mux_sel, 1);
    check_eq("zr_stall_b", stall_b, 0);
    tick();
    b_valid = 1'b0;
    check_eq("zr_rf_we", rf_we, 0);
    check_eq("zr_rf_waddr", rf_waddr, 31);
    check_eq("zr_rf_wdata", rf_wdata, 4);
    check_eq("zr_cnt_hold", conflict_cnt, 5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
